// File: rtl/usr_pkg.sv
// Shared definitions for the shift-register serial link receive side.
package usr_pkg;

  localparam int USR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2,
    RESYNC = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in right-shift register: new bit enters at the MSB, so after WIDTH
// shifts the first (LSB-first) bit lands in bit 0.
module rx_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (en) begin
      q <= {si, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/usr_serial_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, stop bit;
// hands the word off on a valid/ready port with frame-error and overrun pulses.
module usr_serial_rx
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             si,
  input  logic             sen,
  output logic [WIDTH-1:0] po,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             shift_en;
  logic             word_done;
  logic             stop_bad;
  logic             load;
  logic [WIDTH-1:0] shift_q;

  rx_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (shift_en),
    .si    (si),
    .q     (shift_q)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    stop_bad   = 1'b0;
    if (sen) begin
      case (state)
        IDLE: begin
          if (!si) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_next = STOP;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (si) begin
            word_done  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = RESYNC;
          end
        end
        RESYNC: begin
          // A line stuck low must go high before a new start bit counts.
          if (si) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A finished word may replace a pending one only when it is consumed this cycle.
  assign load = word_done && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      po        <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load) begin
        po        <= shift_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      frame_err <= stop_bad;
      overrun   <= word_done && !load;
      busy      <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_usr_serial_rx.sv
// Randomized and directed bench for usr_serial_rx against a word-level handshake model.
module tb_usr_serial_rx;

  localparam int W = 4;

  logic         clk;
  logic         clr_n;
  logic         si;
  logic         sen;
  logic [W-1:0] po;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_po;
  logic         exp_valid;
  logic         rdy_rand;
  int           n_loads;

  usr_serial_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .si        (si),
    .sen       (sen),
    .po        (po),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle. kind: 0 = ordinary bit, 1 = good stop bit, 2 = bad stop bit.
  // rdy_ovr >= 0 forces out_ready for this cycle.
  task automatic cyc(input logic s_en, input logic s_i, input int kind,
                     input logic [W-1:0] w, input int rdy_ovr);
    logic exp_fe;
    logic exp_ov;
    sen = s_en;
    si  = s_i;
    if (rdy_ovr >= 0) out_ready = rdy_ovr[0];
    else if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    exp_fe = (kind == 2);
    exp_ov = 1'b0;
    if (kind == 1) begin
      if (!exp_valid || out_ready) begin
        exp_po    = w;
        exp_valid = 1'b1;
        n_loads++;
      end else begin
        exp_ov = 1'b1;
      end
    end else if (exp_valid && out_ready) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (po !== exp_po) begin
      n_fail++;
      $display("FAIL po: got %h expected %h at %0t", po, exp_po, $time);
    end
    n_checks++;
    if (out_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
    end
    n_checks++;
    if (frame_err !== exp_fe) begin
      n_fail++;
      $display("FAIL frame_err: got %b expected %b at %0t", frame_err, exp_fe, $time);
    end
    n_checks++;
    if (overrun !== exp_ov) begin
      n_fail++;
      $display("FAIL overrun: got %b expected %b at %0t", overrun, exp_ov, $time);
    end
  endtask

  // Full frame; gap strobe-free cycles (random si) precede every strobe.
  task automatic send_frame(input logic [W-1:0] w, input logic stop, input int gap,
                            input int stop_rdy);
    for (int b = 0; b < W + 2; b++) begin
      logic bit_v;
      repeat (gap) cyc(1'b0, 1'($urandom_range(0, 1)), 0, '0, -1);
      if (b == 0) bit_v = 1'b0;
      else if (b <= W) bit_v = w[b-1];
      else bit_v = stop;
      if (b == W + 1) cyc(1'b1, bit_v, stop ? 1 : 2, w, stop_rdy);
      else cyc(1'b1, bit_v, 0, '0, -1);
      if (b == 2) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_mid_frame: got %b expected 1 at %0t", busy, $time);
        end
      end
    end
    $display("frame word=%h stop=%b gap=%0d po=%h out_valid=%b", w, stop, gap, po, out_valid);
  endtask

  task automatic do_reset();
    clr_n     = 1'b0;
    sen       = 1'b0;
    si        = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr_n     = 1'b1;
    exp_po    = '0;
    exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({po, out_valid, frame_err, overrun, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got po=%h v=%b fe=%b ov=%b busy=%b expected all 0",
               po, out_valid, frame_err, overrun, busy);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 0, '0, 0);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_idle: got %b expected 0 at %0t", busy, $time);
      end
    end
    $display("reset and idle line done");
  endtask

  task automatic test_single_frame();
    do_reset();
    send_frame(4'hB, 1'b1, 0, 0);
    repeat (3) cyc(1'b1, 1'b1, 0, '0, 0);
    cyc(1'b1, 1'b1, 0, '0, 1);
    cyc(1'b1, 1'b1, 0, '0, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_frame: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(4'hB, 1'b1, 0, 0);
    send_frame(4'h5, 1'b1, 0, 0);
    cyc(1'b1, 1'b1, 0, '0, 1);
    do_reset();
    send_frame(4'hB, 1'b1, 0, 0);
    send_frame(4'h5, 1'b1, 0, 1);
    cyc(1'b1, 1'b1, 0, '0, 1);
  endtask

  task automatic test_frame_error();
    do_reset();
    send_frame(4'hA, 1'b0, 0, 0);
    repeat (5) cyc(1'b1, 1'b0, 0, '0, 0);
    cyc(1'b1, 1'b1, 0, '0, 0);
    send_frame(4'h3, 1'b1, 0, 0);
    cyc(1'b1, 1'b1, 0, '0, 1);
  endtask

  task automatic test_sparse_strobe();
    do_reset();
    send_frame(4'h9, 1'b1, 2, 0);
    cyc(1'b0, 1'b0, 0, '0, 1);
  endtask

  task automatic test_reset_mid_frame();
    int loads_before;
    do_reset();
    cyc(1'b1, 1'b0, 0, '0, 0);
    cyc(1'b1, 1'b1, 0, '0, 0);
    cyc(1'b1, 1'b1, 0, '0, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_abort: got %b expected 1", busy);
    end
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({po, out_valid, busy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got po=%h v=%b busy=%b expected 0", po, out_valid, busy);
    end
    @(posedge clk);
    #1;
    clr_n     = 1'b1;
    exp_po    = '0;
    exp_valid = 1'b0;
    loads_before = n_loads;
    repeat (3) cyc(1'b1, 1'b1, 0, '0, 0);
    send_frame(4'h6, 1'b1, 0, 0);
    repeat (3) cyc(1'b1, 1'b1, 0, '0, 0);
    n_checks++;
    if (n_loads - loads_before != 1 || po !== 4'h6) begin
      n_fail++;
      $display("FAIL abort_then_frame: got po=%h loads=%0d expected po=6 loads=1",
               po, n_loads - loads_before);
    end
  endtask

  task automatic test_random();
    do_reset();
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [W-1:0] w;
      logic         stop;
      w    = W'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(w, stop, $urandom_range(0, 2), -1);
      if (!stop) cyc(1'b1, 1'b1, 0, '0, -1);
      repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b1, 0, '0, -1);
    end
    rdy_rand = 1'b0;
  endtask

  initial begin
    clr_n     = 1'b0;
    sen       = 1'b0;
    si        = 1'b1;
    out_ready = 1'b0;
    rdy_rand  = 1'b0;
    n_loads   = 0;
    exp_po    = '0;
    exp_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_sparse_strobe();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
